// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a valid/ready handshake and staller control
// (GO / STALL / BUBBLE). It also has a synchronous flush, an optional skid entry
// and a saturating stall-cycle counter.
// With SKID=1, in_ready_o depends only on registered state and on the staller and
// flush inputs, never on out_ready_i. This breaks the combinational ready path
// between stages.
module pipe_stage_skid #(
  parameter int unsigned       DATA_W    = 128,
  parameter int unsigned       SKID      = 1,
  parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        stl_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  output logic [1:0]        occ_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // Encoding equals the number of held entries, so occ_o is the state itself.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  localparam logic [1:0] StlStall  = 2'b01;
  localparam logic [1:0] StlBubble = 2'b10;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic is_stall;
  logic is_bubble;
  logic is_go;
  logic in_fire;
  logic out_fire;

  // 2'b11 is not a defined command and behaves as GO.
  assign is_stall  = (stl_i == StlStall);
  assign is_bubble = (stl_i == StlBubble);
  assign is_go     = !is_stall && !is_bubble;

  assign out_valid_o = (state_q != StEmpty);
  assign out_data_o  = main_q;
  assign occ_o       = state_q;
  assign stall_cnt_o = cnt_q;

  assign out_fire = out_valid_o && out_ready_i && !is_stall && !flush_i;
  assign in_fire  = in_valid_i && in_ready_o;

  // Upstream is accepted only under GO without flush; SKID selects the ready rule.
  always_comb begin
    in_ready_o = 1'b0;
    if (is_go && !flush_i) begin
      if (SKID != 0) begin
        in_ready_o = (state_q != StTwo);
      end else begin
        in_ready_o = !out_valid_o || out_ready_i;
      end
    end
  end

  // Next-state and datapath: flush > STALL > BUBBLE > GO.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = StEmpty;
      main_d  = NOP_VALUE;
      skid_d  = NOP_VALUE;
    end else if (is_stall) begin
      // Everything holds.
    end else if (is_bubble) begin
      if (!out_valid_o || out_fire) begin
        if (state_q == StTwo) begin
          // A held skid entry drains ahead of the bubble so that order is kept.
          main_d  = skid_q;
          skid_d  = NOP_VALUE;
          state_d = StOne;
        end else begin
          main_d  = NOP_VALUE;
          state_d = StEmpty;
        end
      end
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            main_d  = in_data_i;
            state_d = StOne;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            main_d = in_data_i;
          end else if (in_fire) begin
            // Only reachable with SKID=1. With SKID=0, in_fire in StOne implies out_fire.
            skid_d  = in_data_i;
            state_d = StTwo;
          end else if (out_fire) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (out_fire) begin
            main_d  = skid_q;
            skid_d  = NOP_VALUE;
            state_d = StOne;
          end
        end
        default: begin
          state_d = StEmpty;
          main_d  = NOP_VALUE;
          skid_d  = NOP_VALUE;
        end
      endcase
    end
  end

  // The stall counter saturates at all-ones. Only rst clears it; flush does not.
  always_comb begin
    cnt_d = cnt_q;
    if (is_stall && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State and data registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      main_q  <= NOP_VALUE;
      skid_q  <= NOP_VALUE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
